// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
//   state_e        : loader FSM states
//   HDR_BYTES      : bytes in the word-count header
//   BYTES_PER_WORD : bytes assembled into one instruction word
//   LANE_W         : width of the byte-lane counter
package instr_loader_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CHK,
    RUN,
    ERR
  } state_e;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Assembles little-endian 32-bit words from a byte stream.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-low reset
//   clr_i          : restart at byte lane 0
//   byte_en_i      : byte_i is a data byte to place in the current lane
//   byte_i         : data byte
//   last_lane_o    : current lane is the final lane of a word
//   word_valid_o   : one-cycle pulse after the final lane of a word is taken
//   word_o         : last completed word {b3,b2,b1,b0}; holds between pulses
module instr_loader_word_assembler
  import instr_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        last_lane_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [23:0]       shift_q, shift_d;
  logic              word_valid_q, word_valid_d;
  logic [31:0]       word_q, word_d;

  assign last_lane_o = (lane_q == LANE_W'(BYTES_PER_WORD - 1));

  always_comb begin
    lane_d       = lane_q;
    shift_d      = shift_q;
    word_valid_d = 1'b0;
    word_d       = word_q;
    if (clr_i) begin
      lane_d = '0;
    end else if (byte_en_i) begin
      // Bytes enter at the top and move down, so after three bytes the
      // shifter holds {b2,b1,b0} and the fourth byte completes the word.
      shift_d = {byte_i, shift_q[23:8]};
      if (last_lane_o) begin
        lane_d       = '0;
        word_valid_d = 1'b1;
        word_d       = {byte_i, shift_q};
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lane_q       <= '0;
      shift_q      <= '0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
    end else begin
      lane_q       <= lane_d;
      shift_q      <= shift_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/instr_loader.sv
// Boot-time program loader: receives a byte stream (16-bit word count N,
// 4N little-endian data bytes, XOR checksum byte), writes the words to
// instruction memory from address 0 and releases the CPU on a good checksum.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-low reset
//   byte_valid_i      : upstream byte valid
//   byte_data_i       : upstream byte
//   byte_ready_o      : loader accepts a byte this cycle
//   imem_we_o         : one-cycle instruction-memory write strobe
//   imem_addr_o       : word address of the write (holds between writes)
//   imem_data_o       : instruction word to write (holds between writes)
//   start_o           : program loaded and verified; held until reset
//   busy_o            : load in progress (HDR1, DATA, CHK)
//   error_o           : sticky load failure
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              start_o,
  output logic              busy_o,
  output logic              error_o
);

  localparam int unsigned N_W = 8 * HDR_BYTES;
  // Capacity in words, one bit wider than the count so 2^16 is representable.
  localparam logic [N_W:0] MAX_WORDS = (N_W + 1)'(2 ** ADDR_W);

  state_e            state_q, state_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [N_W:0]      widx_q, widx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        csum_q, csum_d;

  logic accept;
  logic wa_clr, wa_en, wa_last;
  logic wa_valid;
  logic [31:0] wa_word;

  // Ready depends only on state (and reset), so bytes can stream 1/cycle.
  assign byte_ready_o = rst_i && (state_q inside {HDR0, HDR1, DATA, CHK});
  assign accept       = byte_valid_i && byte_ready_o;

  instr_loader_word_assembler u_word_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (wa_clr),
    .byte_en_i    (wa_en),
    .byte_i       (byte_data_i),
    .last_lane_o  (wa_last),
    .word_valid_o (wa_valid),
    .word_o       (wa_word)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    widx_d  = widx_q;
    addr_d  = addr_q;
    csum_d  = csum_q;
    wa_clr  = 1'b0;
    wa_en   = 1'b0;
    unique case (state_q)
      HDR0: begin
        if (accept) begin
          n_d[7:0] = byte_data_i;
          csum_d   = csum_q ^ byte_data_i;
          state_d  = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          n_d    = {byte_data_i, n_q[7:0]};
          csum_d = csum_q ^ byte_data_i;
          // Rejecting oversize counts here is what keeps the address from wrapping.
          if ((n_d == '0) || ({1'b0, n_d} > MAX_WORDS)) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
            widx_d  = '0;
            wa_clr  = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          wa_en  = 1'b1;
          csum_d = csum_q ^ byte_data_i;
          if (wa_last) begin
            // Address is registered alongside the assembler's word strobe.
            addr_d = widx_q[ADDR_W-1:0];
            widx_d = widx_q + 1'b1;
            if (widx_d == {1'b0, n_q}) begin
              state_d = CHK;
            end
          end
        end
      end
      CHK: begin
        if (accept) begin
          state_d = (byte_data_i == csum_q) ? RUN : ERR;
        end
      end
      RUN, ERR: begin
      end
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= HDR0;
      n_q     <= '0;
      widx_q  <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
    end
  end

  assign imem_we_o   = wa_valid;
  assign imem_data_o = wa_word;
  assign imem_addr_o = addr_q;
  assign start_o     = (state_q == RUN);
  assign error_o     = (state_q == ERR);
  assign busy_o      = (state_q inside {HDR1, DATA, CHK});

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              start;
  logic              busy;
  logic              error;

  instr_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_data_o  (imem_data),
    .start_o      (start),
    .busy_o       (busy),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t               exp_q[$];
  int                n_checks = 0;
  int                n_pass = 0;
  int                n_writes = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [31:0]       wbuf [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every write strobe is matched against the scoreboard.
  initial begin
    logic prev_we;
    wr_t  e;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_we) begin
        n_writes++;
        last_addr = imem_addr;
        check("we_width", {31'b0, prev_we}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected no write", imem_addr, imem_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {24'b0, imem_addr}, {24'b0, e.addr});
          check("wr_data", imem_data, e.data);
        end
      end
      prev_we = rst_n && imem_we;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [7:0] b);
    int w;
    w = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    if (w == 8) begin
      n_checks++;
      $display("FAIL ready_timeout: ready %0b, expected 1", byte_ready);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int cycles);
    byte_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_stream(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i]);
    byte_valid = 1'b0;
  endtask

  task automatic do_reset(input bit check_outputs);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    if (check_outputs) begin
      check("rst_we",    {31'b0, imem_we},    32'd0);
      check("rst_addr",  {24'b0, imem_addr},  32'd0);
      check("rst_data",  imem_data,           32'd0);
      check("rst_start", {31'b0, start},      32'd0);
      check("rst_busy",  {31'b0, busy},       32'd0);
      check("rst_error", {31'b0, error},      32'd0);
      check("rst_ready", {31'b0, byte_ready}, 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Load wbuf[0..n-1] with a checksum formed from the stream itself.
  task automatic load(input int n, input bit bad_csum, input bit toggle);
    logic [15:0] nn;
    logic [7:0]  c;
    logic [7:0]  b;
    logic [31:0] w;
    nn = 16'(n);
    c  = nn[7:0] ^ nn[15:8];
    send(nn[7:0]);   if (toggle) idle(1);
    send(nn[15:8]);  if (toggle) idle(1);
    for (int i = 0; i < n; i++) begin
      w = wbuf[i];
      exp_q.push_back({ADDR_W'(i), w});
      for (int l = 0; l < 4; l++) begin
        b = w[8*l +: 8];
        c = c ^ b;
        send(b);
        if (toggle) idle(1);
      end
    end
    send(bad_csum ? ~c : c);
    byte_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] s[$];
    int w0;

    // Reset state
    do_reset(1'b1);
    check("idle_ready", {31'b0, byte_ready}, 32'd1);
    check("idle_busy",  {31'b0, busy},       32'd0);

    // Test 1: N=2 back-to-back, hand-computed checksum 0x07
    exp_q.push_back({8'h00, 32'h0010_0513});
    exp_q.push_back({8'h01, 32'h00B5_05B3});
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00, 8'h07};
    send_stream(s);
    check("t1_start",   {31'b0, start},      32'd1);
    check("t1_error",   {31'b0, error},      32'd0);
    check("t1_pending", exp_q.size(),        32'd0);
    idle(3);
    check("t1_start_hold", {31'b0, start},      32'd1);
    check("t1_ready_run",  {31'b0, byte_ready}, 32'd0);
    check("t1_last_data",  imem_data,           32'h00B5_05B3);

    // Test 2: same stream, inverted checksum
    do_reset(1'b0);
    exp_q.push_back({8'h00, 32'h0010_0513});
    exp_q.push_back({8'h01, 32'h00B5_05B3});
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00, 8'hF8};
    send_stream(s);
    idle(2);
    check("t2_error",   {31'b0, error},      32'd1);
    check("t2_start",   {31'b0, start},      32'd0);
    check("t2_ready",   {31'b0, byte_ready}, 32'd0);
    check("t2_pending", exp_q.size(),        32'd0);

    // Test 3a: N=0
    do_reset(1'b0);
    w0 = n_writes;
    s = '{8'h00, 8'h00};
    send_stream(s);
    check("t3a_error", {31'b0, error}, 32'd1);
    idle(4);
    check("t3a_writes", n_writes - w0, 32'd0);
    check("t3a_ready",  {31'b0, byte_ready}, 32'd0);

    // Test 3b: N=257 exceeds capacity
    do_reset(1'b0);
    w0 = n_writes;
    s = '{8'h01, 8'h01};
    send_stream(s);
    check("t3b_error", {31'b0, error}, 32'd1);
    idle(4);
    check("t3b_writes", n_writes - w0, 32'd0);
    check("t3b_start",  {31'b0, start}, 32'd0);

    // Test 4: N=1 with valid toggling
    do_reset(1'b0);
    w0 = n_writes;
    wbuf[0] = 32'hDEAD_BEEF;
    load(1, 1'b0, 1'b1);
    check("t4_start",   {31'b0, start}, 32'd1);
    check("t4_error",   {31'b0, error}, 32'd0);
    check("t4_writes",  n_writes - w0,  32'd1);
    check("t4_pending", exp_q.size(),   32'd0);

    // Test 5: reset after two data bytes, then full reload
    do_reset(1'b0);
    s = '{8'h02, 8'h00, 8'h13, 8'h05};
    send_stream(s);
    check("t5_busy_mid", {31'b0, busy}, 32'd1);
    do_reset(1'b1);
    exp_q.push_back({8'h00, 32'h0010_0513});
    exp_q.push_back({8'h01, 32'h00B5_05B3});
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00, 8'h07};
    send_stream(s);
    check("t5_start",   {31'b0, start}, 32'd1);
    check("t5_pending", exp_q.size(),   32'd0);

    // Test 6: N=256 fills memory exactly
    do_reset(1'b0);
    w0 = n_writes;
    for (int i = 0; i < 256; i++) wbuf[i] = 32'h1000_0000 + 32'(i);
    load(256, 1'b0, 1'b0);
    check("t6_start",     {31'b0, start},     32'd1);
    check("t6_error",     {31'b0, error},     32'd0);
    check("t6_writes",    n_writes - w0,      32'd256);
    check("t6_last_addr", {24'b0, last_addr}, 32'h0000_00FF);
    check("t6_pending",   exp_q.size(),       32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
